// File: rtl/ram_array.sv
// ram_array: single-port synchronous RAM with a self-clearing zero fill.
//
// After reset, or on a clear request while idle, the array is zero-filled one
// word per cycle (busy=1 for exactly DEPTH cycles). While idle, reads and
// writes are accepted at the rising edge. Reads are registered: rdata and the
// one-cycle rvalid pulse appear one cycle after the request. A read and a
// write to the same address in one cycle return the old contents.
//
// Ports:
//   clk     in   clock, all state updates on the rising edge
//   reset   in   synchronous active-high reset; restarts the zero fill
//   addr    in   word address (ADDR_W bits, naturally modulo DEPTH)
//   wdata   in   write data
//   rdata   out  registered read data, held until the next accepted read
//   read    in   read request
//   write   in   write request
//   clear   in   zero-fill request (wins over read/write in the same cycle)
//   rvalid  out  one-cycle pulse when rdata is updated by a read
//   busy    out  high while the zero fill is running
//
// Optional feature, macro RAM_ARRAY_PARITY_EN:
//   each word stores an extra even-parity bit; adds ports
//   par_inj in   on an accepted write, store the inverted parity bit
//   perr    out  with rvalid, stored parity does not match stored data
module ram_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   input  logic              read,
   input  logic              write,
   input  logic              clear,
   output logic              rvalid,
   output logic              busy
`ifdef RAM_ARRAY_PARITY_EN
   ,
   input  logic              par_inj,
   output logic              perr
`endif
);

   localparam int DEPTH = 2**ADDR_W;
`ifdef RAM_ARRAY_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;

   logic [MEM_W-1:0]  r_mem [DEPTH];

   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [MEM_W-1:0]  w_mem_din;
   logic [MEM_W-1:0]  w_wr_word;
   logic [MEM_W-1:0]  w_rd_word;
   logic              w_rd_en;

   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;

   // Stored word: parity bit (if enabled) above the data. Even parity means
   // the XOR over the whole stored word is 0.
`ifdef RAM_ARRAY_PARITY_EN
   assign w_wr_word = {(^wdata) ^ par_inj, wdata};
`else
   assign w_wr_word = wdata;
`endif

   assign w_rd_word = r_mem[addr];

   // Next state and the single memory write port. Reset suppresses both the
   // memory write and the read so an access in a reset cycle has no effect.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mem_we    = 1'b0;
      w_mem_addr  = addr;
      w_mem_din   = w_wr_word;
      w_rd_en     = 1'b0;
      if (!reset) begin
         case (r_state)
            S_CLEAR: begin
               // Zero data with zero parity is a correctly encoded word.
               w_mem_we   = 1'b1;
               w_mem_addr = r_cnt;
               w_mem_din  = '0;
               w_cnt_nxt  = r_cnt + ADDR_W'(1);
               if (r_cnt == '1) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: begin
               if (clear) begin
                  w_state_nxt = S_CLEAR;
                  w_cnt_nxt   = '0;
               end else begin
                  w_mem_we = write;
                  w_rd_en  = read;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_din;
      end
   end

   // Read-first: the array read sees the pre-edge contents even when the
   // same address is written at this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_rd_en;
         if (w_rd_en) begin
            r_rdata <= w_rd_word[DATA_W-1:0];
         end
      end
   end

`ifdef RAM_ARRAY_PARITY_EN
   logic r_perr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perr <= 1'b0;
      end else begin
         r_perr <= w_rd_en & (^w_rd_word);
      end
   end

   assign perr = r_perr;
`endif

   assign rdata  = r_rdata;
   assign rvalid = r_rvalid;
   assign busy   = (r_state == S_CLEAR);

endmodule

// File: tb/tb_ram_array.sv
module tb_ram_array;

   localparam int DW    = 8;
   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic          clear = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          busy;
`ifdef RAM_ARRAY_PARITY_EN
   logic          par_inj = 1'b0;
   logic          perr;
`endif

   always #5 clk = ~clk;

   ram_array #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk    (clk),
      .reset  (reset),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .read   (read),
      .write  (write),
      .clear  (clear),
      .rvalid (rvalid),
      .busy   (busy)
`ifdef RAM_ARRAY_PARITY_EN
      ,
      .par_inj(par_inj),
      .perr   (perr)
`endif
   );

   typedef struct packed {
      logic          rst;
      logic          rd;
      logic          wr;
      logic          clr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          inj;
   } op_t;

   int errors = 0;
   int checks = 0;

   // Reference model of the array contents and of the block's visible state.
   logic [DW-1:0] m_mem [DEPTH];
   logic          m_inj [DEPTH];
   int            m_left = 0;       // remaining clear cycles, 0 = idle
   logic          exp_rv = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   logic          exp_perr = 1'b0;

   // Scoreboard: expected read results, pushed when the read is issued.
   logic [DW-1:0] q_data [$];
   logic          q_perr [$];

   // Drive one cycle of stimulus, advance the model, then wait until just
   // after the rising edge so the outputs can be sampled.
   task automatic step(input op_t o);
      reset = o.rst;
      read  = o.rd;
      write = o.wr;
      clear = o.clr;
      addr  = o.a;
      wdata = o.d;
`ifdef RAM_ARRAY_PARITY_EN
      par_inj = o.inj;
`endif
      exp_rv = 1'b0;
      if (o.rst) begin
         m_left = DEPTH;
         m_rdata = '0;
         q_data.delete();
         q_perr.delete();
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_inj[i] = 1'b0;
         end
      end else if (m_left > 0) begin
         m_left--;
      end else if (o.clr) begin
         m_left = DEPTH;
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_inj[i] = 1'b0;
         end
      end else begin
         if (o.rd) begin
            q_data.push_back(m_mem[o.a]);
            q_perr.push_back(m_inj[o.a]);
            exp_rv = 1'b1;
         end
         if (o.wr) begin
            m_mem[o.a] = o.d;
            m_inj[o.a] = o.inj;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic op_t idle();
      return '{rst: 1'b0, rd: 1'b0, wr: 1'b0, clr: 1'b0, a: '0, d: '0, inj: 1'b0};
   endfunction

   function automatic op_t op(input logic rd, input logic wr, input logic clr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic inj);
      return '{rst: 1'b0, rd: rd, wr: wr, clr: clr, a: a, d: d, inj: inj};
   endfunction

   task automatic test_reset();
      int n;
      int rv_bad;
      op_t o;
      o = idle();
      o.rst = 1'b1;
      step(o);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
      checks++;
      if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata); end
      n = 1;
      rv_bad = 0;
      for (int k = 0; k < DEPTH + 50 && busy === 1'b1; k++) begin
         step(idle());
         if (rvalid !== 1'b0) rv_bad++;
         if (busy === 1'b1) n++;
      end
      checks++;
      if (n != DEPTH) begin errors++; $display("FAIL reset_busy_cycles: got %0d want %0d", n, DEPTH); end
      checks++;
      if (rv_bad != 0) begin errors++; $display("FAIL reset_clear_rvalid: got %0d pulses want 0", rv_bad); end
      step(op(1'b1, 1'b0, 1'b0, 10'd5, 8'h00, 1'b0));
      checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL reset_read5_rvalid: got %b want 1", rvalid); end
      if (q_data.size() > 0) begin
         m_rdata  = q_data.pop_front();
         exp_perr = q_perr.pop_front();
      end
      checks++;
      if (rdata !== 8'h00) begin errors++; $display("FAIL reset_read5_rdata: got %h want 00", rdata); end
      step(idle());
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_read5_pulse: got %b want 0", rvalid); end
   endtask

   task automatic test_back_to_back();
      op_t ops [$];
      ops.push_back(op(1'b0, 1'b1, 1'b0, 10'd1, 8'h05, 1'b0));
      ops.push_back(op(1'b0, 1'b1, 1'b0, 10'd2, 8'h0A, 1'b0));
      ops.push_back(op(1'b1, 1'b0, 1'b0, 10'd1, 8'h00, 1'b0));
      ops.push_back(op(1'b1, 1'b0, 1'b0, 10'd2, 8'h00, 1'b0));
      ops.push_back(idle());
      ops.push_back(idle());
      foreach (ops[i]) begin
         step(ops[i]);
         checks++;
         if (rvalid !== exp_rv) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b want %b", i, rvalid, exp_rv); end
         exp_perr = 1'b0;
         if (rvalid === 1'b1) begin
            if (q_data.size() == 0) begin
               errors++; $display("FAIL b2b_unexpected_rvalid[%0d]: got 1 want 0", i);
            end else begin
               m_rdata  = q_data.pop_front();
               exp_perr = q_perr.pop_front();
            end
         end
         checks++;
         if (rdata !== m_rdata) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rdata, m_rdata); end
      end
   endtask

   task automatic test_read_first();
      op_t ops [$];
      ops.push_back(op(1'b0, 1'b1, 1'b0, 10'd3, 8'h11, 1'b0));
      ops.push_back(idle());
      ops.push_back(op(1'b1, 1'b1, 1'b0, 10'd3, 8'h22, 1'b0));
      ops.push_back(op(1'b1, 1'b0, 1'b0, 10'd3, 8'h00, 1'b0));
      ops.push_back(idle());
      foreach (ops[i]) begin
         step(ops[i]);
         checks++;
         if (rvalid !== exp_rv) begin errors++; $display("FAIL rf_rvalid[%0d]: got %b want %b", i, rvalid, exp_rv); end
         if (rvalid === 1'b1) begin
            if (q_data.size() == 0) begin
               errors++; $display("FAIL rf_unexpected_rvalid[%0d]: got 1 want 0", i);
            end else begin
               m_rdata  = q_data.pop_front();
               exp_perr = q_perr.pop_front();
            end
         end
         checks++;
         if (rdata !== m_rdata) begin errors++; $display("FAIL rf_rdata[%0d]: got %h want %h", i, rdata, m_rdata); end
      end
   endtask

   task automatic test_boundary();
      op_t ops [$];
      ops.push_back(op(1'b0, 1'b1, 1'b0, 10'd1023, 8'hA5, 1'b0));
      ops.push_back(op(1'b0, 1'b1, 1'b0, 10'd0,    8'h3C, 1'b0));
      ops.push_back(op(1'b1, 1'b0, 1'b0, 10'd1023, 8'h00, 1'b0));
      ops.push_back(op(1'b1, 1'b0, 1'b0, 10'd0,    8'h00, 1'b0));
      ops.push_back(op(1'b1, 1'b0, 1'b0, 10'd1,    8'h00, 1'b0));
      ops.push_back(idle());
      ops.push_back(idle());
      foreach (ops[i]) begin
         step(ops[i]);
         checks++;
         if (rvalid !== exp_rv) begin errors++; $display("FAIL bound_rvalid[%0d]: got %b want %b", i, rvalid, exp_rv); end
         if (rvalid === 1'b1) begin
            if (q_data.size() == 0) begin
               errors++; $display("FAIL bound_unexpected_rvalid[%0d]: got 1 want 0", i);
            end else begin
               m_rdata  = q_data.pop_front();
               exp_perr = q_perr.pop_front();
            end
         end
         checks++;
         if (rdata !== m_rdata) begin errors++; $display("FAIL bound_rdata[%0d]: got %h want %h", i, rdata, m_rdata); end
      end
   endtask

`ifdef RAM_ARRAY_PARITY_EN
   task automatic test_parity();
      op_t ops [$];
      ops.push_back(op(1'b0, 1'b1, 1'b0, 10'd4, 8'h07, 1'b1));
      ops.push_back(op(1'b1, 1'b0, 1'b0, 10'd4, 8'h00, 1'b0));
      ops.push_back(op(1'b0, 1'b1, 1'b0, 10'd4, 8'h07, 1'b0));
      ops.push_back(op(1'b1, 1'b0, 1'b0, 10'd4, 8'h00, 1'b0));
      ops.push_back(idle());
      foreach (ops[i]) begin
         step(ops[i]);
         checks++;
         if (rvalid !== exp_rv) begin errors++; $display("FAIL par_rvalid[%0d]: got %b want %b", i, rvalid, exp_rv); end
         exp_perr = 1'b0;
         if (rvalid === 1'b1) begin
            if (q_data.size() == 0) begin
               errors++; $display("FAIL par_unexpected_rvalid[%0d]: got 1 want 0", i);
            end else begin
               m_rdata  = q_data.pop_front();
               exp_perr = q_perr.pop_front();
            end
         end
         checks++;
         if (rdata !== m_rdata) begin errors++; $display("FAIL par_rdata[%0d]: got %h want %h", i, rdata, m_rdata); end
         checks++;
         if (perr !== exp_perr) begin errors++; $display("FAIL par_perr[%0d]: got %b want %b", i, perr, exp_perr); end
      end
   endtask
`endif

   task automatic test_busy_ignore();
      int rv_bad;
      // Enter a clear, then on its 10th cycle write and read address 3,
      // which the fill has already passed, so a leaked write would persist.
      step(op(1'b0, 1'b0, 1'b1, 10'd0, 8'h00, 1'b0));
      for (int k = 0; k < 9; k++) step(idle());
      step(op(1'b1, 1'b1, 1'b1, 10'd3, 8'hAA, 1'b0));
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid_clear: got %b want 1", busy); end
      rv_bad = (rvalid !== 1'b0) ? 1 : 0;
      for (int k = 0; k < DEPTH + 50 && busy === 1'b1; k++) begin
         step(idle());
         if (rvalid !== 1'b0) rv_bad++;
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_timeout: got %b want 0", busy); end
      checks++;
      if (rv_bad != 0) begin errors++; $display("FAIL busy_rvalid: got %0d pulses want 0", rv_bad); end
      step(op(1'b1, 1'b0, 1'b0, 10'd3, 8'h00, 1'b0));
      checks++;
      if (rvalid !== 1'b1) begin errors++; $display("FAIL busy_read3_rvalid: got %b want 1", rvalid); end
      if (q_data.size() > 0) begin
         m_rdata  = q_data.pop_front();
         exp_perr = q_perr.pop_front();
      end
      checks++;
      if (rdata !== m_rdata) begin errors++; $display("FAIL busy_read3_rdata: got %h want %h", rdata, m_rdata); end
      // Clear and write together in an idle cycle: the write is dropped.
      step(op(1'b0, 1'b1, 1'b1, 10'd8, 8'h33, 1'b0));
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL clrwr_busy: got %b want 1", busy); end
      for (int k = 0; k < DEPTH + 50 && busy === 1'b1; k++) step(idle());
      step(op(1'b1, 1'b0, 1'b0, 10'd8, 8'h00, 1'b0));
      if (q_data.size() > 0) begin
         m_rdata  = q_data.pop_front();
         exp_perr = q_perr.pop_front();
      end
      checks++;
      if (rvalid !== 1'b1 || rdata !== m_rdata) begin
         errors++; $display("FAIL clrwr_read8: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", rvalid, rdata, m_rdata);
      end
   endtask

   task automatic test_reset_midclear();
      int n;
      op_t o;
      step(op(1'b0, 1'b1, 1'b0, 10'd9, 8'h5A, 1'b0));
      step(op(1'b1, 1'b0, 1'b0, 10'd9, 8'h00, 1'b0));
      if (q_data.size() > 0) begin
         m_rdata  = q_data.pop_front();
         exp_perr = q_perr.pop_front();
      end
      checks++;
      if (rvalid !== 1'b1 || rdata !== m_rdata) begin
         errors++; $display("FAIL midrst_pre_read: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", rvalid, rdata, m_rdata);
      end
      step(op(1'b0, 1'b0, 1'b1, 10'd0, 8'h00, 1'b0));
      for (int k = 0; k < 500; k++) step(idle());
      // Reset at counter 500 with a read in the same cycle.
      o = op(1'b1, 1'b0, 1'b0, 10'd9, 8'h00, 1'b0);
      o.rst = 1'b1;
      step(o);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b want 1", busy); end
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid: got %b want 0", rvalid); end
      checks++;
      if (rdata !== m_rdata) begin errors++; $display("FAIL midrst_rdata: got %h want %h", rdata, m_rdata); end
      n = 1;
      for (int k = 0; k < DEPTH + 50 && busy === 1'b1; k++) begin
         step(idle());
         if (busy === 1'b1) n++;
      end
      checks++;
      if (n != DEPTH) begin errors++; $display("FAIL midrst_busy_cycles: got %0d want %0d", n, DEPTH); end
      step(op(1'b1, 1'b0, 1'b0, 10'd9, 8'h00, 1'b0));
      if (q_data.size() > 0) begin
         m_rdata  = q_data.pop_front();
         exp_perr = q_perr.pop_front();
      end
      checks++;
      if (rvalid !== 1'b1 || rdata !== m_rdata) begin
         errors++; $display("FAIL midrst_read9: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", rvalid, rdata, m_rdata);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_read_first();
      test_boundary();
`ifdef RAM_ARRAY_PARITY_EN
      test_parity();
`endif
      test_busy_ignore();
      test_reset_midclear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
